// File: rtl/vector_chunk_streamer_pkg.sv
// Shared definitions for the vector chunk streamer.
//   DEF_ELEMENT_WIDTH / DEF_NO_OF_UNITS : default element width and lanes per chunk
//   state_e                             : streamer FSM state encoding
//   num_chunks()                        : ceil(noe / units), the number of chunks a vector occupies
package vector_chunk_streamer_pkg;

  localparam int DEF_ELEMENT_WIDTH = 32;
  localparam int DEF_NO_OF_UNITS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_READY  = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

  // Exact ceiling division, so a vector that fills its last chunk gets no spare chunk.
  function automatic int num_chunks(input int noe, input int units);
    return (noe + units - 1) / units;
  endfunction

endpackage

// File: rtl/vector_chunk_streamer_if.sv
// Handshake bundle between a vector producer/consumer and the chunk streamer.
//   master : the environment side (drives load/write/stream controls and chunk_ready)
//   slave  : the streamer side (drives wr_ready, chunk stream and status flags)
interface vector_chunk_streamer_if
  import vector_chunk_streamer_pkg::*;
#(
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS
) ();

  logic                                 load_start;
  logic                                 wr_valid;
  logic [ELEMENT_WIDTH-1:0]             wr_data;
  logic                                 wr_ready;
  logic                                 stream_start;
  logic                                 chunk_valid;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] chunk_data;
  logic                                 chunk_ready;
  logic                                 chunk_last;
  logic                                 loaded;
  logic                                 stream_done;

  modport master (
    output load_start, wr_valid, wr_data, stream_start, chunk_ready,
    input  wr_ready, chunk_valid, chunk_data, chunk_last, loaded, stream_done
  );

  modport slave (
    input  load_start, wr_valid, wr_data, stream_start, chunk_ready,
    output wr_ready, chunk_valid, chunk_data, chunk_last, loaded, stream_done
  );

endinterface

// File: rtl/vector_chunk_buffer.sv
// Chunk storage: NUM_CHUNKS rows of NO_OF_UNITS lanes, ELEMENT_WIDTH bits each.
//   clk        : write clock
//   wr_chunk   : row written this cycle
//   wr_lane_en : one enable per lane (at most one set per cycle in normal use)
//   wr_data    : element written into every enabled lane
//   rd_chunk   : row read combinationally
//   rd_data    : full row, lane k at [k*ELEMENT_WIDTH +: ELEMENT_WIDTH]
// Contents are deliberately not reset; the streamer masks unused lanes on read.
module vector_chunk_buffer #(
  parameter int NUM_CHUNKS    = 2,
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int CIDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                                 clk,
  input  logic [CIDX_W-1:0]                    wr_chunk,
  input  logic [NO_OF_UNITS-1:0]               wr_lane_en,
  input  logic [ELEMENT_WIDTH-1:0]             wr_data,
  input  logic [CIDX_W-1:0]                    rd_chunk,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data
);

  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_r [NUM_CHUNKS];

  // Per-lane element writes into the addressed row
  always_ff @(posedge clk) begin
    for (int k = 0; k < NO_OF_UNITS; k++) begin
      if (wr_lane_en[k]) begin
        mem_r[wr_chunk][k*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= wr_data;
      end
    end
  end

  assign rd_data = mem_r[rd_chunk];

endmodule

// File: rtl/vector_chunk_streamer.sv
// Loads an NOE-element vector one element at a time, then streams it out as
// ceil(NOE/NO_OF_UNITS) wide chunks with valid/ready flow control. The vector
// is retained after streaming so it can be replayed without reloading.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of vector_chunk_streamer_if (load/write/stream handshakes)
module vector_chunk_streamer
  import vector_chunk_streamer_pkg::*;
#(
  parameter int NOE           = 10,
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS
) (
  input  logic                    clk,
  input  logic                    reset,
  vector_chunk_streamer_if.slave  bus
);

  localparam int NUM_CHUNKS = num_chunks(NOE, NO_OF_UNITS);
  localparam int CIDX_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int LANE_W     = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;
  localparam int DW         = ELEMENT_WIDTH * NO_OF_UNITS;

  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'((NOE - 1) % NO_OF_UNITS);
  localparam logic [LANE_W-1:0] TOP_LANE   = LANE_W'(NO_OF_UNITS - 1);

  state_e              state_r;
  logic [CIDX_W-1:0]   wr_chunk_r;
  logic [LANE_W-1:0]   wr_lane_r;
  logic [CIDX_W-1:0]   rd_idx_r;
  logic                wr_ready_r;
  logic                chunk_valid_r;
  logic                chunk_last_r;
  logic                loaded_r;
  logic                stream_done_r;
  logic [DW-1:0]       chunk_data_r;

  logic                wr_accept_s;
  logic                wr_last_s;
  logic                chunk_accept_s;
  logic                rd_last_s;
  logic [CIDX_W-1:0]   rd_sel_s;
  logic [NO_OF_UNITS-1:0] wr_lane_en_s;
  logic [DW-1:0]       rd_raw_s;
  logic [DW-1:0]       rd_masked_s;

  // Handshake qualifiers and the row to present next
  always_comb begin
    // A load_start in LOAD restarts the vector, so the concurrent element is dropped.
    wr_accept_s    = (state_r == ST_LOAD) && bus.wr_valid && !bus.load_start;
    wr_last_s      = (wr_chunk_r == LAST_CHUNK) && (wr_lane_r == LAST_LANE);
    chunk_accept_s = chunk_valid_r && bus.chunk_ready;
    rd_last_s      = (rd_idx_r == LAST_CHUNK);
    // chunk_data is registered, so the buffer is read one row ahead of the
    // row being presented; outside STREAM the look-ahead row is chunk 0.
    if ((state_r == ST_STREAM) && !rd_last_s) begin
      rd_sel_s = rd_idx_r + CIDX_W'(1'b1);
    end else begin
      rd_sel_s = '0;
    end
  end

  // One-hot lane enable for the element being accepted
  always_comb begin
    wr_lane_en_s = '0;
    for (int k = 0; k < NO_OF_UNITS; k++) begin
      wr_lane_en_s[k] = wr_accept_s && (wr_lane_r == LANE_W'(k));
    end
  end

  vector_chunk_buffer #(
    .NUM_CHUNKS    (NUM_CHUNKS),
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .NO_OF_UNITS   (NO_OF_UNITS),
    .CIDX_W        (CIDX_W)
  ) u_buffer (
    .clk        (clk),
    .wr_chunk   (wr_chunk_r),
    .wr_lane_en (wr_lane_en_s),
    .wr_data    (bus.wr_data),
    .rd_chunk   (rd_sel_s),
    .rd_data    (rd_raw_s)
  );

  // Zero every lane whose global element index lies past the end of the vector
  always_comb begin
    rd_masked_s = '0;
    for (int k = 0; k < NO_OF_UNITS; k++) begin
      if ((int'(rd_sel_s) * NO_OF_UNITS + k) < NOE) begin
        rd_masked_s[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = rd_raw_s[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end else begin
        rd_masked_s[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
      end
    end
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      wr_chunk_r    <= '0;
      wr_lane_r     <= '0;
      rd_idx_r      <= '0;
      wr_ready_r    <= 1'b0;
      chunk_valid_r <= 1'b0;
      chunk_last_r  <= 1'b0;
      loaded_r      <= 1'b0;
      stream_done_r <= 1'b0;
      chunk_data_r  <= '0;
    end else begin
      stream_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.load_start) begin
            state_r    <= ST_LOAD;
            wr_chunk_r <= '0;
            wr_lane_r  <= '0;
            wr_ready_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.load_start) begin
            wr_chunk_r <= '0;
            wr_lane_r  <= '0;
          end else if (wr_accept_s) begin
            if (wr_last_s) begin
              state_r    <= ST_READY;
              wr_ready_r <= 1'b0;
              loaded_r   <= 1'b1;
            end else if (wr_lane_r == TOP_LANE) begin
              wr_lane_r  <= '0;
              wr_chunk_r <= wr_chunk_r + CIDX_W'(1'b1);
            end else begin
              wr_lane_r  <= wr_lane_r + LANE_W'(1'b1);
            end
          end
        end
        ST_READY: begin
          if (bus.load_start) begin
            state_r    <= ST_LOAD;
            loaded_r   <= 1'b0;
            wr_ready_r <= 1'b1;
            wr_chunk_r <= '0;
            wr_lane_r  <= '0;
          end else if (bus.stream_start) begin
            state_r       <= ST_STREAM;
            rd_idx_r      <= '0;
            chunk_valid_r <= 1'b1;
            chunk_data_r  <= rd_masked_s;
            chunk_last_r  <= (LAST_CHUNK == '0);
          end
        end
        ST_STREAM: begin
          if (chunk_accept_s) begin
            if (rd_last_s) begin
              state_r       <= ST_READY;
              chunk_valid_r <= 1'b0;
              chunk_last_r  <= 1'b0;
              stream_done_r <= 1'b1;
              chunk_data_r  <= '0;
            end else begin
              rd_idx_r     <= rd_sel_s;
              chunk_data_r <= rd_masked_s;
              chunk_last_r <= (rd_sel_s == LAST_CHUNK);
            end
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          wr_ready_r    <= 1'b0;
          chunk_valid_r <= 1'b0;
          chunk_last_r  <= 1'b0;
          loaded_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready    = wr_ready_r;
  assign bus.chunk_valid = chunk_valid_r;
  assign bus.chunk_data  = chunk_data_r;
  assign bus.chunk_last  = chunk_last_r;
  assign bus.loaded      = loaded_r;
  assign bus.stream_done = stream_done_r;

endmodule

// File: tb/tb_vector_chunk_streamer.sv
// Self-checking bench for vector_chunk_streamer: one instance with NOE=10
// (padded final chunk) and one with NOE=16 (exactly full chunks). Expected
// chunks are queued when streaming is requested and popped on each handshake.
module tb_vector_chunk_streamer;

  localparam int W  = 32;
  localparam int U  = 8;
  localparam int DW = W * U;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            idx;
  } exp_t;

  logic clk;
  logic reset;
  logic sel;  // 0: NOE=10 instance, 1: NOE=16 instance

  logic          load_start;
  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          stream_start;
  logic          chunk_ready;

  logic          o_wr_ready;
  logic          o_chunk_valid;
  logic [DW-1:0] o_chunk_data;
  logic          o_chunk_last;
  logic          o_loaded;
  logic          o_stream_done;

  int   pass_cnt;
  int   total_cnt;
  exp_t sb_q[$];

  vector_chunk_streamer_if #(.ELEMENT_WIDTH(W), .NO_OF_UNITS(U)) ifa ();
  vector_chunk_streamer_if #(.ELEMENT_WIDTH(W), .NO_OF_UNITS(U)) ifb ();

  vector_chunk_streamer #(.NOE(10), .ELEMENT_WIDTH(W), .NO_OF_UNITS(U)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  vector_chunk_streamer #(.NOE(16), .ELEMENT_WIDTH(W), .NO_OF_UNITS(U)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  assign ifa.load_start   = load_start   & ~sel;
  assign ifa.wr_valid     = wr_valid     & ~sel;
  assign ifa.wr_data      = wr_data;
  assign ifa.stream_start = stream_start & ~sel;
  assign ifa.chunk_ready  = chunk_ready  & ~sel;

  assign ifb.load_start   = load_start   & sel;
  assign ifb.wr_valid     = wr_valid     & sel;
  assign ifb.wr_data      = wr_data;
  assign ifb.stream_start = stream_start & sel;
  assign ifb.chunk_ready  = chunk_ready  & sel;

  assign o_wr_ready    = sel ? ifb.wr_ready    : ifa.wr_ready;
  assign o_chunk_valid = sel ? ifb.chunk_valid : ifa.chunk_valid;
  assign o_chunk_data  = sel ? ifb.chunk_data  : ifa.chunk_data;
  assign o_chunk_last  = sel ? ifb.chunk_last  : ifa.chunk_last;
  assign o_loaded      = sel ? ifb.loaded      : ifa.loaded;
  assign o_stream_done = sel ? ifb.stream_done : ifa.stream_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected chunks for a vector whose element i holds base+i.
  task automatic push_expected(input int base, input int noe);
    int nch;
    exp_t e;
    nch = (noe + U - 1) / U;
    for (int c = 0; c < nch; c++) begin
      e.data = '0;
      for (int k = 0; k < U; k++) begin
        if (c * U + k < noe) e.data[k*W +: W] = W'(base + c * U + k);
      end
      e.last = (c == nch - 1);
      e.idx  = c;
      sb_q.push_back(e);
    end
  endtask

  // Writes elements base..base+noe-1; optionally issues load_start first.
  task automatic load_vector(input int base, input int noe, input bit pulse, input string name);
    int i;
    int guard;
    if (pulse) begin
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
    end
    i = 0;
    guard = 0;
    while (i < noe && guard < 60) begin
      wr_valid = 1'b1;
      wr_data  = W'(base + i);
      if (o_wr_ready === 1'b1) i++;
      guard++;
      tick();
    end
    wr_valid = 1'b0;
    total_cnt++;
    if (i !== noe) $display("FAIL %s_load_timeout: accepted %0d want %0d", name, i, noe);
    else pass_cnt++;
    total_cnt++;
    if ({o_loaded, o_wr_ready} !== 2'b10)
      $display("FAIL %s_loaded_flags: loaded,wr_ready=%b want 10", name, {o_loaded, o_wr_ready});
    else pass_cnt++;
  endtask

  // Streams the loaded vector, holding chunk_ready low for stall_n cycles on chunk stall_idx.
  task automatic stream_vector(input int stall_idx, input int stall_n, input string name);
    int cyc;
    int stall;
    int exp_cyc;
    exp_cyc = sb_q.size() + stall_n;
    stream_start = 1'b1;
    chunk_ready  = 1'b1;
    tick();
    stream_start = 1'b0;
    total_cnt++;
    if (o_chunk_valid !== 1'b1) $display("FAIL %s_latency: chunk_valid=%b want 1", name, o_chunk_valid);
    else pass_cnt++;
    cyc = 0;
    stall = 0;
    while (sb_q.size() > 0 && cyc < 40) begin
      total_cnt++;
      if (o_chunk_valid !== 1'b1) begin
        $display("FAIL %s_valid_held: chunk_valid=%b want 1", name, o_chunk_valid);
      end else begin
        pass_cnt++;
        total_cnt++;
        if (o_chunk_data !== sb_q[0].data)
          $display("FAIL %s_data%0d: got %h want %h", name, sb_q[0].idx, o_chunk_data, sb_q[0].data);
        else pass_cnt++;
        total_cnt++;
        if (o_chunk_last !== sb_q[0].last)
          $display("FAIL %s_last%0d: got %b want %b", name, sb_q[0].idx, o_chunk_last, sb_q[0].last);
        else pass_cnt++;
        if (sb_q[0].idx == stall_idx && stall < stall_n) begin
          chunk_ready = 1'b0;
          stall++;
        end else begin
          chunk_ready = 1'b1;
          void'(sb_q.pop_front());
        end
      end
      cyc++;
      tick();
    end
    chunk_ready = 1'b0;
    total_cnt++;
    if (sb_q.size() != 0 || cyc != exp_cyc) begin
      $display("FAIL %s_cycles: took %0d cycles (%0d left) want %0d", name, cyc, sb_q.size(), exp_cyc);
      sb_q.delete();
    end else pass_cnt++;
    total_cnt++;
    if ({o_stream_done, o_chunk_valid, o_chunk_last} !== 3'b100)
      $display("FAIL %s_done_pulse: done,valid,last=%b want 100", name,
               {o_stream_done, o_chunk_valid, o_chunk_last});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({o_stream_done, o_loaded} !== 2'b01)
      $display("FAIL %s_after_done: done,loaded=%b want 01", name, {o_stream_done, o_loaded});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({ifa.wr_ready, ifa.chunk_valid, ifa.chunk_last, ifa.loaded, ifa.stream_done} !== 5'b0)
      $display("FAIL reset_a: outputs=%b want 00000",
               {ifa.wr_ready, ifa.chunk_valid, ifa.chunk_last, ifa.loaded, ifa.stream_done});
    else pass_cnt++;
    total_cnt++;
    if ({ifb.wr_ready, ifb.chunk_valid, ifb.chunk_last, ifb.loaded, ifb.stream_done} !== 5'b0)
      $display("FAIL reset_b: outputs=%b want 00000",
               {ifb.wr_ready, ifb.chunk_valid, ifb.chunk_last, ifb.loaded, ifb.stream_done});
    else pass_cnt++;
    // stream_start in IDLE must not start anything
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    total_cnt++;
    if (o_chunk_valid !== 1'b0) $display("FAIL idle_stream_ignored: chunk_valid=%b want 0", o_chunk_valid);
    else pass_cnt++;
  endtask

  task automatic test_stream_basic();
    load_vector(1, 10, 1'b1, "basic");
    push_expected(1, 10);
    stream_vector(-1, 0, "basic");
  endtask

  task automatic test_backpressure();
    push_expected(1, 10);
    stream_vector(1, 3, "stall");
  endtask

  task automatic test_replay();
    push_expected(1, 10);
    stream_vector(-1, 0, "replay");
  endtask

  task automatic test_reset_mid_stream();
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    total_cnt++;
    if (o_chunk_valid !== 1'b1) $display("FAIL midrst_chunk0: chunk_valid=%b want 1", o_chunk_valid);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({o_wr_ready, o_chunk_valid, o_chunk_last, o_loaded, o_stream_done} !== 5'b0)
      $display("FAIL midrst_outputs: outputs=%b want 00000",
               {o_wr_ready, o_chunk_valid, o_chunk_last, o_loaded, o_stream_done});
    else pass_cnt++;
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      total_cnt++;
      if ({o_chunk_valid, o_loaded, o_wr_ready} !== 3'b000)
        $display("FAIL midrst_idle%0d: valid,loaded,wr_ready=%b want 000", n,
                 {o_chunk_valid, o_loaded, o_wr_ready});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_load_wins();
    load_vector(100, 10, 1'b1, "wins_first");
    load_start   = 1'b1;
    stream_start = 1'b1;
    tick();
    load_start   = 1'b0;
    stream_start = 1'b0;
    total_cnt++;
    if ({o_wr_ready, o_loaded, o_chunk_valid} !== 3'b100)
      $display("FAIL load_wins: wr_ready,loaded,valid=%b want 100", {o_wr_ready, o_loaded, o_chunk_valid});
    else pass_cnt++;
    load_vector(200, 10, 1'b0, "wins_reload");
    push_expected(200, 10);
    stream_vector(-1, 0, "wins_stream");
  endtask

  task automatic test_noe16();
    sel = 1'b1;
    tick();
    load_vector(1, 16, 1'b1, "noe16");
    push_expected(1, 16);
    stream_vector(-1, 0, "noe16");
    sel = 1'b0;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    sel          = 1'b0;
    reset        = 1'b1;
    load_start   = 1'b0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    stream_start = 1'b0;
    chunk_ready  = 1'b0;
    #1;
    test_reset();
    test_stream_basic();
    test_backpressure();
    test_replay();
    test_reset_mid_stream();
    test_load_wins();
    test_noe16();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vector_chunk_streamer.md
VECTOR_CHUNK_STREAMER -- requirements
Module: vector_chunk_streamer

Interface
REQ-001 SHALL have parameter NOE, default 10, meaning number of vector elements.
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 32, meaning bits per element.
REQ-003 SHALL have parameter NO_OF_UNITS, default 8, meaning elements per chunk (dot-product lanes).
REQ-004 SHALL have port clk, input, 1, meaning clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port load_start, input, 1, meaning begin loading a new vector.
REQ-007 SHALL have port wr_valid, input, 1, meaning wr_data valid.
REQ-008 SHALL have port wr_data, input, ELEMENT_WIDTH, meaning next element, index order 0..NOE-1.
REQ-009 SHALL have port wr_ready, output, 1, meaning element accepted when wr_valid&&wr_ready.
REQ-010 SHALL have port stream_start, input, 1, meaning begin streaming the loaded vector.
REQ-011 SHALL have port chunk_valid, output, 1, meaning chunk_data valid.
REQ-012 SHALL have port chunk_data, output, ELEMENT_WIDTH*NO_OF_UNITS, meaning one chunk; lane k at bits [k*W +: W].
REQ-013 SHALL have port chunk_ready, input, 1, meaning consumer accepts chunk.
REQ-014 SHALL have port chunk_last, output, 1, meaning current chunk is final chunk.
REQ-015 SHALL have port loaded, output, 1, meaning complete vector held.
REQ-016 SHALL have port stream_done, output, 1, meaning one-cycle pulse after final chunk handshake.

Function
REQ-017 SHALL derive NUM_CHUNKS = ceil(NOE/NO_OF_UNITS); no extra chunk when NOE divisible by NO_OF_UNITS.
REQ-018 SHALL implement FSM states IDLE, LOAD, READY, STREAM.
REQ-019 IDLE: load_start -> LOAD; stream_start ignored.
REQ-020 LOAD: wr_ready=1; each accepted element stored at chunk i/NO_OF_UNITS, lane i%NO_OF_UNITS; after element NOE-1 accepted -> READY next cycle.
REQ-021 LOAD: load_start restarts element index at 0; stream_start ignored.
REQ-022 READY: loaded=1; load_start -> LOAD (loaded cleared); stream_start -> STREAM with chunk index 0; load_start wins when both asserted.
REQ-023 STREAM: chunk_valid=1, chunk_data = chunk[idx]; idx advances on chunk_valid&&chunk_ready.
REQ-024 chunk_valid SHALL rise the cycle after the stream_start edge (one-cycle latency); one chunk per cycle under continuous chunk_ready.
REQ-025 chunk_data and chunk_last SHALL hold stable while chunk_valid&&!chunk_ready.
REQ-026 chunk_last SHALL equal (idx==NUM_CHUNKS-1) during STREAM, else 0.
REQ-027 Lanes with global index >= NOE SHALL read as zero regardless of buffer contents (padding).
REQ-028 Final chunk handshake -> READY, stream_done=1 for exactly the following cycle; vector retained for replay.
REQ-029 STREAM: load_start and stream_start ignored.
REQ-030 wr_ready=0 outside LOAD; chunk_valid=0 outside STREAM.

Reset
REQ-031 reset SHALL force IDLE, element/chunk indices 0, and wr_ready, chunk_valid, chunk_last, loaded, stream_done all 0 next cycle, including mid-LOAD or mid-STREAM.
REQ-032 Buffer contents need not be cleared by reset; padding rule REQ-027 guarantees zero pad lanes.

Structure
REQ-033 Shared package SHALL hold ELEMENT_WIDTH, NO_OF_UNITS defaults, NUM_CHUNKS function, and FSM state enumeration.
REQ-034 Chunk buffer SHALL be one sub-module vector_chunk_buffer (NUM_CHUNKS x ELEMENT_WIDTH*NO_OF_UNITS, per-lane write enable, async read).

Verification (NOE=10, W=32, U=8)
REQ-035 Load 1..10, stream, chunk_ready=1 -> chunk0 lanes 1..8 chunk_last=0; chunk1 lanes 9,10,0x0 x6 chunk_last=1; stream_done pulse next cycle.
REQ-036 chunk_ready low 3 cycles on chunk1 -> chunk_data/chunk_last stable 3 cycles, accepted on 4th.
REQ-037 Second stream_start in READY -> identical two chunks replayed without reload.
REQ-038 reset asserted during chunk0 -> all outputs 0 next cycle, stream_start then ignored (IDLE).
REQ-039 load_start and stream_start together in READY -> LOAD entered, loaded=0, no chunk_valid.
REQ-040 NOE=16 -> exactly 2 chunks, lanes 1..16, no padding lanes, chunk_last on second.
